accel_feeder: RTL and testbench

ACCEL_FEEDER -- requirements
Module: accel_feeder

---
 rtl/accel_feeder.sv | 113 +++++++++++
 tb/tb_accel_feeder.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accel_feeder.sv
// accel_feeder: operand FIFO feeding a start/busy accelerator and holding its result for a ready/valid sink.
// Define ACCEL_FEEDER_STATS_EN to enable the completed-job counter on done_cnt_o.
module accel_feeder #(
    parameter int DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [7:0]               a_i,
    input  logic [7:0]               b_i,
    output logic                     acc_start_o,
    output logic [7:0]               acc_a_o,
    output logic [7:0]               acc_b_o,
    input  logic                     acc_busy_i,
    input  logic [15:0]              acc_y_i,
    output logic                     res_valid_o,
    input  logic                     res_ready_i,
    output logic [15:0]              res_y_o,
    output logic [$clog2(DEPTH):0]   fifo_count_o,
    output logic [15:0]              done_cnt_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

    state_t        state_q;
    logic [15:0]   mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          start_q, res_valid_q;
    logic [7:0]    a_q, b_q;
    logic [15:0]   res_y_q;
    logic          push, pop, capture;

    assign in_ready_o   = count_q != CW'(DEPTH);
    assign push         = in_valid_i && in_ready_o;
    // A pop is the only way into START, so it is gated on the result slot being free.
    assign pop          = (state_q == IDLE) && (count_q != '0) && (!res_valid_q || res_ready_i);
    assign capture      = (state_q == WAIT_DONE) && !acc_busy_i;
    assign count_d      = (push && !pop) ? count_q + CW'(1) :
                          (pop && !push) ? count_q - CW'(1) : count_q;

    assign fifo_count_o = count_q;
    assign acc_start_o  = start_q;
    assign acc_a_o      = a_q;
    assign acc_b_o      = b_q;
    assign res_valid_o  = res_valid_q;
    assign res_y_o      = res_y_q;

    always_ff @(posedge clk_i) begin
        if (push) mem_q[wr_ptr_q] <= {a_i, b_i};
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop) rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q     <= IDLE;
            start_q     <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            res_valid_q <= 1'b0;
            res_y_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (pop) begin
                        {a_q, b_q} <= mem_q[rd_ptr_q];
                        start_q    <= 1'b1;
                        state_q    <= START;
                    end
                end
                START: begin
                    start_q <= 1'b0;
                    state_q <= WAIT_BUSY;
                end
                WAIT_BUSY: if (acc_busy_i) state_q <= WAIT_DONE;
                WAIT_DONE: if (!acc_busy_i) state_q <= IDLE;
            endcase
            if (capture) begin
                res_valid_q <= 1'b1;
                res_y_q     <= acc_y_i;
            end else if (res_valid_q && res_ready_i) begin
                res_valid_q <= 1'b0;
            end
        end
    end

`ifdef ACCEL_FEEDER_STATS_EN
    logic [15:0] done_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) done_q <= '0;
        else if (capture) done_q <= done_q + 16'd1;
    end

    assign done_cnt_o = done_q;
`else
    assign done_cnt_o = '0;
`endif
endmodule

// File: tb/tb_accel_feeder.sv
// tb_accel_feeder: table-driven and scoreboard-checked bench for accel_feeder with a stub accelerator.
module tb_accel_feeder;
    localparam int DEPTH = 4;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        in_valid_i = 1'b0;
    logic        in_ready_o;
    logic [7:0]  a_i = '0, b_i = '0;
    logic        acc_start_o;
    logic [7:0]  acc_a_o, acc_b_o;
    logic        acc_busy_i = 1'b0;
    logic [15:0] acc_y_i = '0;
    logic        res_valid_o;
    logic        res_ready_i = 1'b1;
    logic [15:0] res_y_o;
    logic [2:0]  fifo_count_o;
    logic [15:0] done_cnt_o;

    accel_feeder #(.DEPTH(DEPTH)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
        .a_i(a_i), .b_i(b_i), .acc_start_o(acc_start_o), .acc_a_o(acc_a_o), .acc_b_o(acc_b_o),
        .acc_busy_i(acc_busy_i), .acc_y_i(acc_y_i), .res_valid_o(res_valid_o),
        .res_ready_i(res_ready_i), .res_y_o(res_y_o), .fifo_count_o(fifo_count_o),
        .done_cnt_o(done_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] y;
    } vec_t;

    int          total = 0;
    int          bad = 0;
    int          starts = 0;
    int          starts0 = 0;
    bit          hold = 0;
    bit          prev_start = 0;
    logic [15:0] exp_q [$];
    vec_t        tbl [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    // Stub accelerator: the three named operand pairs give fixed results, anything else gives {a,b}.
    function automatic logic [15:0] acc_fn(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd1 && b == 8'd2) return 16'h0013;
        if (a == 8'd255 && b == 8'd0) return 16'h02FD;
        if (a == 8'd10 && b == 8'd7) return 16'h00CC;
        return {a, b};
    endfunction

    initial begin
        forever begin
            @(negedge clk_i);
            if (rst_i && acc_start_o) begin
                repeat (2) @(negedge clk_i);
                acc_busy_i = 1'b1;
                repeat (3) @(negedge clk_i);
                while (hold) @(negedge clk_i);
                acc_y_i    = acc_fn(acc_a_o, acc_b_o);
                acc_busy_i = 1'b0;
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk_i);
            #1;
            if (rst_i) begin
                if (acc_start_o) begin
                    starts++;
                    chk("start_pulse_width", 32'(prev_start), 32'd0);
                end
                if (res_valid_o && res_ready_i) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL res_unexpected: got %0h want none", res_y_o);
                    end else begin
                        chk("res_y", 32'(res_y_o), 32'(exp_q.pop_front()));
                    end
                end
            end
            prev_start = acc_start_o;
        end
    end

    task automatic push(input logic [7:0] a, input logic [7:0] b, input logic [15:0] y);
        bit ok = 0;
        for (int k = 0; k < 100 && !ok; k++) begin
            @(negedge clk_i);
            in_valid_i = 1'b1;
            a_i = a;
            b_i = b;
            if (in_ready_o) begin
                exp_q.push_back(y);
                @(posedge clk_i);
                ok = 1;
            end
        end
        if (!ok) begin
            total++;
            bad++;
            $display("FAIL push_timeout: got no accept want accept of %0h/%0h", a, b);
        end
    endtask

    task automatic idle_in();
        @(negedge clk_i);
        in_valid_i = 1'b0;
    endtask

    task automatic wait_drain(input int budget);
        for (int k = 0; k < budget && exp_q.size() != 0; k++) @(negedge clk_i);
        if (exp_q.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic wait_busy();
        for (int k = 0; k < 50 && !acc_busy_i; k++) @(negedge clk_i);
        chk("busy_seen", 32'(acc_busy_i), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_in_ready"}, 32'(in_ready_o), 32'd1);
        chk({tag, "_count"}, 32'(fifo_count_o), 32'd0);
        chk({tag, "_start"}, 32'(acc_start_o), 32'd0);
        chk({tag, "_acc_ab"}, 32'({acc_a_o, acc_b_o}), 32'd0);
        chk({tag, "_res_valid"}, 32'(res_valid_o), 32'd0);
        chk({tag, "_res_y"}, 32'(res_y_o), 32'd0);
        chk({tag, "_done"}, 32'(done_cnt_o), 32'd0);
    endtask

    initial begin
        tbl[0] = '{8'd1,    8'd2,    16'h0013};
        tbl[1] = '{8'd255,  8'd0,    16'h02FD};
        tbl[2] = '{8'd10,   8'd7,    16'h00CC};
        tbl[3] = '{8'h12,   8'h34,   16'h1234};
        tbl[4] = '{8'hAB,   8'hCD,   16'hABCD};
        tbl[5] = '{8'h00,   8'hFF,   16'h00FF};
        tbl[6] = '{8'hFF,   8'hFF,   16'hFFFF};

        repeat (2) @(negedge clk_i);
        chk_reset_outputs("rst0");
        rst_i = 1'b1;

        push(8'd1, 8'd2, 16'h0013);
        idle_in();
        chk("single_count_after_push", 32'(fifo_count_o), 32'd1);
        chk("single_no_early_start", 32'(acc_start_o), 32'd0);
        @(negedge clk_i);
        chk("single_start_after_pop", 32'(acc_start_o), 32'd1);
        chk("single_count_after_pop", 32'(fifo_count_o), 32'd0);
        wait_drain(100);
        chk("single_res_cleared", 32'(res_valid_o), 32'd0);
        chk("single_start_count", 32'(starts), 32'd1);

        for (int i = 0; i < 7; i++) push(tbl[i].a, tbl[i].b, tbl[i].y);
        idle_in();
        wait_drain(500);

        hold = 1;
        push(8'h11, 8'h22, 16'h1122);
        idle_in();
        wait_busy();
        push(8'h31, 8'h32, 16'h3132);
        push(8'h41, 8'h42, 16'h4142);
        push(8'h51, 8'h52, 16'h5152);
        push(8'h61, 8'h62, 16'h6162);
        idle_in();
        chk("full_in_ready", 32'(in_ready_o), 32'd0);
        chk("full_count", 32'(fifo_count_o), 32'd4);
        hold = 0;
        push(8'h71, 8'h72, 16'h7172);
        idle_in();
        wait_drain(500);

        res_ready_i = 1'b0;
        starts0 = starts;
        push(8'd255, 8'd0, 16'h02FD);
        push(8'd10, 8'd7, 16'h00CC);
        idle_in();
        for (int k = 0; k < 100 && !res_valid_o; k++) @(negedge clk_i);
        repeat (20) @(negedge clk_i);
        chk("bp_res_valid", 32'(res_valid_o), 32'd1);
        chk("bp_res_hold", 32'(res_y_o), 32'h02FD);
        chk("bp_no_second_start", 32'(starts - starts0), 32'd1);
        chk("bp_count", 32'(fifo_count_o), 32'd1);
        res_ready_i = 1'b1;
        wait_drain(200);
        chk("bp_second_start", 32'(starts - starts0), 32'd2);

        hold = 1;
        push(8'd3, 8'd4, 16'h0304);
        idle_in();
        wait_busy();
        push(8'd5, 8'd6, 16'h0506);
        idle_in();
        @(negedge clk_i);
        rst_i = 1'b0;
        #1;
        chk_reset_outputs("rst_mid");
        exp_q.delete();
        @(negedge clk_i);
        rst_i = 1'b1;
        hold = 0;
        starts0 = starts;
        repeat (20) @(negedge clk_i);
        chk("rst_no_start", 32'(starts - starts0), 32'd0);
        chk("rst_count_after", 32'(fifo_count_o), 32'd0);
        chk("rst_res_after", 32'(res_valid_o), 32'd0);

        for (int i = 3; i < 6; i++) push(tbl[i].a, tbl[i].b, tbl[i].y);
        idle_in();
        wait_drain(300);
        repeat (2) @(negedge clk_i);
`ifdef ACCEL_FEEDER_STATS_EN
        chk("done_cnt", 32'(done_cnt_o), 32'd3);
`else
        chk("done_cnt", 32'(done_cnt_o), 32'd0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
